// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and
// data access, with round-robin on contention and a per-access timeout.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                im_req,
  input  logic [ADDR_W-1:0]   im_addr,
  input  logic                dm_req,
  input  logic [DATA_W/8-1:0] dm_write_en,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W-1:0]   im_rdata,
  output logic                im_valid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_valid,
  output logic                cpu_stall,
  output logic                mem_req,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                err
);

  localparam int         BE_W     = DATA_W / 8;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_IM, BUSY_DM} state_t;
  typedef enum logic {GRANT_IM, GRANT_DM} grant_t;

  state_t     state, state_d;
  grant_t     last_grant;
  logic [7:0] cnt;
  logic       im_eff, dm_eff;
  logic       grant_im, grant_dm, done, abort;

  // A requester is masked in its own valid cycle so a held request is not
  // granted a second time before the CPU has consumed the result.
  assign im_eff    = im_req & ~im_valid;
  assign dm_eff    = dm_req & ~dm_valid;
  assign cpu_stall = im_eff | dm_eff;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state;
    grant_im = 1'b0;
    grant_dm = 1'b0;
    done     = 1'b0;
    abort    = 1'b0;
    unique case (state)
      IDLE: begin
        if (im_eff && (!dm_eff || last_grant == GRANT_DM)) begin
          grant_im = 1'b1;
          state_d  = BUSY_IM;
        end else if (dm_eff) begin
          grant_dm = 1'b1;
          state_d  = BUSY_DM;
        end
      end
      BUSY_IM, BUSY_DM: begin
        if (mem_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (cnt == CNT_LAST) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req    <= 1'b0;
      mem_we     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      im_valid   <= 1'b0;
      dm_valid   <= 1'b0;
      im_rdata   <= '0;
      dm_rdata   <= '0;
      err        <= 1'b0;
      last_grant <= GRANT_IM;
      cnt        <= '0;
    end else begin
      im_valid <= 1'b0;
      dm_valid <= 1'b0;

      if (grant_im || grant_dm) begin
        mem_req    <= 1'b1;
        mem_addr   <= grant_im ? im_addr : dm_addr;
        mem_we     <= grant_im ? {BE_W{1'b0}} : dm_write_en;
        mem_wdata  <= grant_im ? {DATA_W{1'b0}} : dm_wdata;
        last_grant <= grant_im ? GRANT_IM : GRANT_DM;
        cnt        <= '0;
      end

      if (done || abort) begin
        mem_req <= 1'b0;
        mem_we  <= '0;
        // An aborted access returns zero data and latches the sticky error.
        if (state == BUSY_IM) begin
          im_rdata <= done ? mem_rdata : {DATA_W{1'b0}};
          im_valid <= 1'b1;
        end else begin
          dm_rdata <= done ? mem_rdata : {DATA_W{1'b0}};
          dm_valid <= 1'b1;
        end
        if (abort) err <= 1'b1;
      end else if (state != IDLE) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester drivers push expected
// results, a memory responder models wait states, a monitor checks outputs.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        im_req = 1'b0, dm_req = 1'b0;
  logic [31:0] im_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [3:0]  dm_write_en = '0;
  logic [31:0] im_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        im_valid, dm_valid, cpu_stall, mem_req, err;
  logic        mem_ready = 1'b0;
  logic [3:0]  mem_we;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .im_req(im_req), .im_addr(im_addr),
    .dm_req(dm_req), .dm_write_en(dm_write_en), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .im_rdata(im_rdata), .im_valid(im_valid),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .err(err)
  );

  typedef struct {
    logic [31:0] data;
    bit          chk;
    bit          dead;
    int          busy;
  } exp_t;

  exp_t        im_q[$], dm_q[$];
  logic [31:0] model_mem[logic [31:0]];
  logic [31:0] phys_mem[logic [31:0]];
  int          checks = 0, errors = 0;

  // Address map of the modelled memory: 0x1xxx is instruction space, a 0xFxx
  // page never answers, and addr[4:2] mod 6 gives the wait-state count.
  function automatic bit is_im(input logic [31:0] a);
    return a[13:12] == 2'd1;
  endfunction
  function automatic bit is_dead(input logic [31:0] a);
    return a[11:8] == 4'hf;
  endfunction
  function automatic int lat_of(input logic [31:0] a);
    return int'(a[4:2]) % 6;
  endfunction
  function automatic logic [31:0] im_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction
  function automatic logic [31:0] dm_init(input logic [31:0] a);
    return a ^ 32'hc0de_0000;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_valid(input bit for_im);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(for_im ? im_valid : dm_valid) && n < 300);
    check(for_im ? "im_handshake" : "dm_handshake",
          64'(for_im ? im_valid : dm_valid), 64'd1);
  endtask

  task automatic im_xact(input logic [31:0] addr, input int gap);
    exp_t e;
    e.dead = is_dead(addr);
    e.chk  = 1'b1;
    e.data = e.dead ? 32'h0 : im_word(addr);
    e.busy = e.dead ? TO : lat_of(addr) + 1;
    im_q.push_back(e);
    im_addr = addr;
    im_req  = 1'b1;
    wait_valid(1'b1);
    if (gap > 0) begin
      im_req = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic dm_xact(input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] wd, input int gap);
    exp_t        e;
    logic [31:0] cur;
    cur    = model_mem.exists(addr) ? model_mem[addr] : dm_init(addr);
    e.dead = is_dead(addr);
    e.busy = e.dead ? TO : lat_of(addr) + 1;
    e.chk  = e.dead || (we == 4'h0);
    e.data = e.dead ? 32'h0 : cur;
    if (!e.dead && we != 4'h0) model_mem[addr] = merge(cur, wd, we);
    dm_q.push_back(e);
    dm_write_en = we;
    dm_addr     = addr;
    dm_wdata    = wd;
    dm_req      = 1'b1;
    wait_valid(1'b0);
    if (gap > 0) begin
      dm_req = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  // Memory responder: answers after the address-selected number of wait states.
  bit          r_active = 1'b0;
  int          r_wait, r_lat;
  logic [31:0] r_cur;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        r_active  = 1'b0;
        mem_ready = 1'b0;
      end else if (mem_req) begin
        if (!r_active) begin
          r_active = 1'b1;
          r_wait   = 0;
          r_lat    = is_dead(mem_addr) ? -1 : lat_of(mem_addr);
        end else begin
          r_wait++;
        end
        if (r_wait == r_lat) begin
          mem_ready = 1'b1;
          if (is_im(mem_addr)) begin
            mem_rdata = im_word(mem_addr);
          end else begin
            r_cur     = phys_mem.exists(mem_addr) ? phys_mem[mem_addr] : dm_init(mem_addr);
            mem_rdata = r_cur;
            if (mem_we != 4'h0) phys_mem[mem_addr] = merge(r_cur, mem_wdata, mem_we);
          end
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        r_active  = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: grant order, handshake timing, stability and completion data.
  bit          in_xact = 1'b0, owner_im = 1'b0, last_im = 1'b1, err_exp = 1'b0;
  bit          prev_idle = 1'b0, prev_im_eff = 1'b0, prev_dm_eff = 1'b0;
  bit          ending, exp_im;
  int          busy_cnt = 0;
  logic [31:0] prev_im_addr, prev_dm_addr, prev_dm_wdata, snap_addr, snap_wdata;
  logic [3:0]  prev_dm_we, snap_we;
  exp_t        got;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        in_xact     = 1'b0;
        last_im     = 1'b1;
        err_exp     = 1'b0;
        prev_idle   = 1'b0;
        prev_im_eff = 1'b0;
        prev_dm_eff = 1'b0;
      end else begin
        check("cpu_stall", 64'(cpu_stall),
              64'((im_req && !im_valid) || (dm_req && !dm_valid)));
        ending = in_xact && !mem_req;
        check("im_valid_timing", 64'(im_valid), 64'(ending && owner_im));
        check("dm_valid_timing", 64'(dm_valid), 64'(ending && !owner_im));
        if (im_valid) begin
          if (im_q.size() == 0) check("im_q_nonempty", 64'(im_q.size()), 64'd1);
          else begin
            got = im_q.pop_front();
            if (got.dead) err_exp = 1'b1;
            if (got.chk) check("im_rdata", 64'(im_rdata), 64'(got.data));
            check("im_busy_cycles", 64'(busy_cnt), 64'(got.busy));
          end
        end
        if (dm_valid) begin
          if (dm_q.size() == 0) check("dm_q_nonempty", 64'(dm_q.size()), 64'd1);
          else begin
            got = dm_q.pop_front();
            if (got.dead) err_exp = 1'b1;
            if (got.chk) check("dm_rdata", 64'(dm_rdata), 64'(got.data));
            check("dm_busy_cycles", 64'(busy_cnt), 64'(got.busy));
          end
        end
        if (im_valid || dm_valid) check("err", 64'(err), 64'(err_exp));
        if (ending) in_xact = 1'b0;

        if (mem_req && !in_xact) begin
          check("grant_after_idle_request", 64'(prev_idle && (prev_im_eff || prev_dm_eff)), 64'd1);
          exp_im = prev_im_eff && (!prev_dm_eff || !last_im);
          check("grant_owner", 64'(is_im(mem_addr)), 64'(exp_im));
          check("grant_addr", 64'(mem_addr), 64'(exp_im ? prev_im_addr : prev_dm_addr));
          check("grant_we", 64'(mem_we), 64'(exp_im ? 4'h0 : prev_dm_we));
          check("grant_wdata", 64'(mem_wdata), 64'(exp_im ? 32'h0 : prev_dm_wdata));
          last_im    = exp_im;
          owner_im   = exp_im;
          in_xact    = 1'b1;
          busy_cnt   = 1;
          snap_addr  = mem_addr;
          snap_we    = mem_we;
          snap_wdata = mem_wdata;
        end else if (mem_req) begin
          busy_cnt++;
          check("mem_addr_stable", 64'(mem_addr), 64'(snap_addr));
          check("mem_we_wdata_stable", {28'h0, mem_we, mem_wdata}, {28'h0, snap_we, snap_wdata});
        end else if (prev_idle && (prev_im_eff || prev_dm_eff)) begin
          check("grant_taken", 64'(mem_req), 64'd1);
        end

        prev_idle     = !mem_req;
        prev_im_eff   = im_req && !im_valid;
        prev_dm_eff   = dm_req && !dm_valid;
        prev_im_addr  = im_addr;
        prev_dm_addr  = dm_addr;
        prev_dm_we    = dm_write_en;
        prev_dm_wdata = dm_wdata;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          n;

    // Reset with both requesters already waiting, then contention: DM first.
    fork
      begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_mem_req", 64'(mem_req), 64'd0);
        check("reset_valids", {62'h0, im_valid, dm_valid}, 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_cpu_stall", 64'(cpu_stall), 64'd1);
        rst = 1'b0;
      end
      for (int i = 0; i < 3; i++) im_xact(32'h0000_1100, (i == 2) ? 1 : 0);
      for (int i = 0; i < 3; i++) dm_xact(4'b0011, 32'h0000_2004, 32'h0000_a5a5, (i == 2) ? 1 : 0);
    join

    // Lone fetch, long wait-state read, then a timeout followed by normal accesses.
    im_xact(32'h0000_1000, 1);
    dm_xact(4'h0, 32'h0000_3014, 32'h0, 1);
    dm_xact(4'h0, 32'h0000_2004, 32'h0, 1);
    im_xact(32'h0000_1f00, 1);
    im_xact(32'h0000_1008, 1);
    check("err_sticky", 64'(err), 64'd1);

    // Randomized traffic from both requesters.
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          a = {20'h00001, 12'($urandom) & 12'h0fc};
          if ($urandom_range(0, 9) == 0) a[11:8] = 4'hf;
          im_xact(a, $urandom_range(0, 2));
        end
        im_req = 1'b0;
      end
      begin
        for (int i = 0; i < 60; i++) begin
          a = 32'h0000_2000 | (32'($urandom_range(0, 15)) << 2);
          if ($urandom_range(0, 9) == 0) a[11:8] = 4'hf;
          dm_xact(($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, a, $urandom,
                  $urandom_range(0, 2));
        end
        dm_req = 1'b0;
      end
    join

    // Reset in the second busy cycle of a data read; it must be re-granted.
    fork
      dm_xact(4'h0, 32'h0000_2034, 32'h0, 1);
      begin
        n = 0;
        while (!mem_req && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midop_reset_mem_req", 64'(mem_req), 64'd0);
        check("midop_reset_dm_valid", 64'(dm_valid), 64'd0);
        check("midop_reset_err", 64'(err), 64'd0);
        rst = 1'b0;
      end
    join

    repeat (5) @(posedge clk);
    #1;
    check("im_q_drained", 64'(im_q.size()), 64'd0);
    check("dm_q_drained", 64'(dm_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
